tl_road_model: RTL and testbench

// - Road/intersection model; the opposite end of the traffic-light controller interface.
// - Consumes light codes La/Lb and produces sensor signals Ta/Tb.
// - Keeps one car queue per street:
//   - arrival pulses add cars;
//   - a green light drains cars at a fixed rate.
// - Flags unsafe light combinations.
// - Closes the loop around the controller in system benches.

---
 rtl/tl_pkg.sv | 11 +
 rtl/tl_road_lane.sv | 69 ++++++
 rtl/tl_road_model.sv | 79 +++++++
 tb/tb_tl_road_model.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Light-code definitions shared by the traffic-light controller and the road model.
package tl_pkg;

  typedef enum logic [1:0] {
    L_GREEN   = 2'b00,
    L_YELLOW  = 2'b01,
    L_RED     = 2'b10,
    L_ILLEGAL = 2'b11
  } light_t;

endpackage

// File: rtl/tl_road_lane.sv
// One street of the road model: car queue counter, departure timer and full detect.
// Optional 16-bit departure counter when TL_ROAD_STATS_EN is defined.
module tl_road_lane
  import tl_pkg::*;
#(
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned DEPART_CYC = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             arr,
  input  logic [1:0]       light,
  output logic [CNT_W-1:0] cnt,
  output logic             dep,
  output logic             arr_drop
`ifdef TL_ROAD_STATS_EN
  ,
  output logic [15:0]      served
`endif
);

  localparam int unsigned       TMR_W    = (DEPART_CYC > 1) ? $clog2(DEPART_CYC) : 1;
  localparam logic [TMR_W-1:0]  TMR_LAST = TMR_W'(DEPART_CYC - 1);

  logic [TMR_W-1:0] tmr;
  logic [TMR_W-1:0] tmr_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             green_run;
  logic             full;

  always_comb begin
    green_run = (light == L_GREEN) && (cnt != '0);
    dep       = green_run && (tmr == TMR_LAST);
    full      = (cnt == '1);
    arr_drop  = arr && !dep && full;

    // Any non-green cycle or empty queue discards a partial green interval.
    tmr_nxt = '0;
    if (green_run && !dep)
      tmr_nxt = tmr + 1'b1;

    // Simultaneous arrival and departure cancel, even on a full queue.
    cnt_nxt = cnt;
    if (arr && !dep && !full)
      cnt_nxt = cnt + 1'b1;
    else if (dep && !arr)
      cnt_nxt = cnt - 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      tmr <= '0;
    end else begin
      cnt <= cnt_nxt;
      tmr <= tmr_nxt;
    end
  end

`ifdef TL_ROAD_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      served <= '0;
    else if (dep)
      served <= served + 16'd1;
  end
`endif

endmodule

// File: rtl/tl_road_model.sv
// Road/intersection model driven by controller light codes; produces traffic sensors Ta/Tb.
// Define TL_ROAD_STATS_EN to add per-street departure counters served_a/served_b.
module tl_road_model
  import tl_pkg::*;
#(
  parameter int unsigned CNT_W      = 4,
  parameter int unsigned DEPART_CYC = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             arr_a,
  input  logic             arr_b,
  input  logic [1:0]       La,
  input  logic [1:0]       Lb,
  output logic             Ta,
  output logic             Tb,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic             ovf,
  output logic             conflict,
  output logic             illegal
`ifdef TL_ROAD_STATS_EN
  ,
  output logic [15:0]      served_a,
  output logic [15:0]      served_b
`endif
);

  logic dep_a, dep_b;
  logic drop_a, drop_b;

  tl_road_lane #(.CNT_W(CNT_W), .DEPART_CYC(DEPART_CYC)) u_lane_a (
    .clk      (clk),
    .reset_n  (reset_n),
    .arr      (arr_a),
    .light    (La),
    .cnt      (cnt_a),
    .dep      (dep_a),
    .arr_drop (drop_a)
`ifdef TL_ROAD_STATS_EN
    ,
    .served   (served_a)
`endif
  );

  tl_road_lane #(.CNT_W(CNT_W), .DEPART_CYC(DEPART_CYC)) u_lane_b (
    .clk      (clk),
    .reset_n  (reset_n),
    .arr      (arr_b),
    .light    (Lb),
    .cnt      (cnt_b),
    .dep      (dep_b),
    .arr_drop (drop_b)
`ifdef TL_ROAD_STATS_EN
    ,
    .served   (served_b)
`endif
  );

  assign Ta = (cnt_a != '0);
  assign Tb = (cnt_b != '0);

  // An illegal 11 code is non-RED, so it also counts toward conflict.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ovf      <= 1'b0;
      conflict <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      ovf      <= ovf | drop_a | drop_b;
      conflict <= conflict | ((La != L_RED) && (Lb != L_RED));
      illegal  <= illegal | (La == L_ILLEGAL) | (Lb == L_ILLEGAL);
    end
  end

  logic unused_dep;
  assign unused_dep = dep_a ^ dep_b;

endmodule

// File: tb/tb_tl_road_model.sv
// Self-checking bench for tl_road_model: vector table plus hand-written corner sequences.
module tb_tl_road_model;

  localparam logic [1:0] G  = 2'b00;
  localparam logic [1:0] Y  = 2'b01;
  localparam logic [1:0] R  = 2'b10;
  localparam logic [1:0] IL = 2'b11;

  typedef struct {
    logic       arr_a;
    logic       arr_b;
    logic [1:0] la;
    logic [1:0] lb;
    logic [3:0] cnt_a;
    logic [3:0] cnt_b;
    logic       ovf;
    logic       conflict;
    logic       illegal;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       arr_a = 1'b0;
  logic       arr_b = 1'b0;
  logic [1:0] La = R;
  logic [1:0] Lb = G;
  logic       Ta, Tb;
  logic [3:0] cnt_a, cnt_b;
  logic       ovf, conflict, illegal;
`ifdef TL_ROAD_STATS_EN
  logic [15:0] served_a, served_b;
`endif

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  vec_t        sb[$];
  vec_t        tbl[$];

  always #5 clk = ~clk;

  tl_road_model #(.CNT_W(4), .DEPART_CYC(2)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .arr_a    (arr_a),
    .arr_b    (arr_b),
    .La       (La),
    .Lb       (Lb),
    .Ta       (Ta),
    .Tb       (Tb),
    .cnt_a    (cnt_a),
    .cnt_b    (cnt_b),
    .ovf      (ovf),
    .conflict (conflict),
    .illegal  (illegal)
`ifdef TL_ROAD_STATS_EN
    ,
    .served_a (served_a),
    .served_b (served_b)
`endif
  );

  function automatic vec_t mk(input logic aa, input logic ab, input logic [1:0] la,
                              input logic [1:0] lb, input int ca, input int cb,
                              input logic o, input logic c, input logic i);
    vec_t v;
    v.arr_a = aa; v.arr_b = ab; v.la = la; v.lb = lb;
    v.cnt_a = 4'(ca); v.cnt_b = 4'(cb);
    v.ovf = o; v.conflict = c; v.illegal = i;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_state(input string tag, input vec_t e);
    check({tag, " cnt_a"},    int'(cnt_a),    int'(e.cnt_a));
    check({tag, " cnt_b"},    int'(cnt_b),    int'(e.cnt_b));
    check({tag, " Ta"},       int'(Ta),       int'(e.cnt_a != 4'd0));
    check({tag, " Tb"},       int'(Tb),       int'(e.cnt_b != 4'd0));
    check({tag, " ovf"},      int'(ovf),      int'(e.ovf));
    check({tag, " conflict"}, int'(conflict), int'(e.conflict));
    check({tag, " illegal"},  int'(illegal),  int'(e.illegal));
  endtask

  // Called at posedge+1: drive, queue the expectation, then compare after the next edge.
  task automatic step(input string tag, input vec_t v);
    vec_t e;
    arr_a = v.arr_a; arr_b = v.arr_b; La = v.la; Lb = v.lb;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, " scoreboard empty"}, 1, 0);
    end else begin
      e = sb.pop_front();
      check_state(tag, e);
    end
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    arr_a = 1'b0; arr_b = 1'b0; La = R; Lb = G;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_state(tag, mk(0, 0, R, G, 0, 0, 0, 0, 0));
  endtask

  initial begin
    // Fill A with Lb green (B empty), drain A at one car per two green cycles,
    // fill B to overflow, then a one-cycle GREEN/YELLOW conflict.
    tbl.push_back(mk(1, 0, R, G, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, R, G, 2, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, R, G, 3, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, G, R, 3, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, G, R, 2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, G, R, 2, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, G, R, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, G, R, 1, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, G, R, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, G, R, 0, 0, 0, 0, 0));
    for (int k = 1; k <= 15; k++)
      tbl.push_back(mk(0, 1, R, R, 0, k, 0, 0, 0));
    tbl.push_back(mk(0, 1, R, R, 0, 15, 1, 0, 0));
    tbl.push_back(mk(0, 0, G, Y, 0, 15, 1, 1, 0));
    tbl.push_back(mk(0, 0, R, R, 0, 15, 1, 1, 0));
    tbl.push_back(mk(0, 0, R, G, 0, 15, 1, 1, 0));

    #1;
    do_reset("reset");

    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("tbl[%0d]", i), tbl[i]);
`ifdef TL_ROAD_STATS_EN
      if (i == 8) check("served_a after drain", int'(served_a), 3);
`endif
    end

    // Full B queue under green with arrivals held: departure edges keep 15 without ovf.
    do_reset("reset2");
    for (int k = 1; k <= 15; k++)
      step("fullq fill", mk(0, 1, R, R, 0, k, 0, 0, 0));
    step("fullq g0",  mk(0, 0, R, G, 0, 15, 0, 0, 0));
    step("fullq dep", mk(0, 1, R, G, 0, 15, 0, 0, 0));
    step("fullq drp", mk(0, 1, R, G, 0, 15, 1, 0, 0));
    step("fullq dp2", mk(0, 1, R, G, 0, 15, 1, 0, 0));
    step("fullq t1",  mk(0, 0, R, G, 0, 15, 1, 0, 0));
    step("fullq out", mk(0, 0, R, G, 0, 14, 1, 0, 0));

    // Illegal code on A: sets illegal and conflict, kills the partial green interval.
    do_reset("reset3");
    step("ill fill1", mk(1, 0, R, R, 1, 0, 0, 0, 0));
    step("ill fill2", mk(1, 0, R, R, 2, 0, 0, 0, 0));
    step("ill g1",    mk(0, 0, G, R, 2, 0, 0, 0, 0));
    step("ill code",  mk(0, 0, IL, G, 2, 0, 0, 1, 1));
    step("ill g1b",   mk(0, 0, G, R, 2, 0, 0, 1, 1));
    step("ill dep",   mk(0, 0, G, R, 1, 0, 0, 1, 1));
    step("ill g1c",   mk(0, 0, G, R, 1, 0, 0, 1, 1));

    // Asynchronous reset mid-drain: clears between clock edges.
    reset_n = 1'b0;
    #2;
    check_state("async rst", mk(0, 0, G, R, 0, 0, 0, 0, 0));
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    step("post rst g", mk(0, 0, G, R, 0, 0, 0, 0, 0));
    step("post rst a", mk(1, 0, G, R, 1, 0, 0, 0, 0));
    step("post rst b", mk(0, 0, G, R, 1, 0, 0, 0, 0));
    step("post rst c", mk(0, 0, G, R, 0, 0, 0, 0, 0));
`ifdef TL_ROAD_STATS_EN
    check("served_a after reset", int'(served_a), 1);
`endif

    check("scoreboard drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
